// File: rtl/cordic_pkg.sv
// cordic_pkg
//   Shared definitions for the fixed-point cosine datapath: the fixed-point
//   sample format (also used by the cosine core and the float converters)
//   and the state encoding of the result accumulator.
package cordic_pkg;

  // Signed fixed-point sample format: FIXED_W bits, FRAC_BITS fractional bits
  localparam int FIXED_W   = 32;
  localparam int FRAC_BITS = 22;

  // Accumulator command states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    FINISH = 2'd2
  } acc_state_t;

endpackage

// File: rtl/fixed_saturate.sv
// fixed_saturate
//   Combinational arithmetic right shift by SHIFT followed by signed
//   saturation from IN_W bits down to OUT_W bits.
// Ports:
//   in_value   in   IN_W    signed wide value (e.g. accumulator)
//   out_value  out  OUT_W   shifted, saturated value
//   sat        out  1       1 when the shifted value did not fit in OUT_W
module fixed_saturate #(
  parameter int IN_W  = 40,
  parameter int OUT_W = 32,
  parameter int SHIFT = 0
) (
  input  logic signed [IN_W-1:0]  in_value,
  output logic signed [OUT_W-1:0] out_value,
  output logic                    sat
);

  logic signed [IN_W-1:0] shifted;
  logic [IN_W-OUT_W:0]    upper;

  // The shifted value fits in OUT_W exactly when every bit from the OUT_W
  // sign position upward is a copy of the sign bit.
  always_comb begin
    shifted = in_value >>> SHIFT;
    upper   = shifted[IN_W-1:OUT_W-1];
    sat     = !((&upper) || !(|upper));
    if (!sat) begin
      out_value = shifted[OUT_W-1:0];
    end else if (shifted[IN_W-1]) begin
      out_value = {1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      out_value = {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/cordic_result_accumulator.sv
// cordic_result_accumulator
//   Sums a commanded number of signed fixed-point cosine results and returns
//   the shifted, saturated total. Runs in the clock/clk_en domain of the
//   CORDIC datapath; clk_en low freezes every register.
// Ports:
//   clock     in   1       rising-edge clock
//   reset     in   1       synchronous, active-high reset
//   clk_en    in   1       global enable
//   start     in   1       command strobe, accepted only in IDLE
//   count     in   CNT_W   number of samples to sum
//   in_valid  in   1       upstream sample valid
//   in_data   in   DATA_W  signed fixed-point sample
//   in_ready  out  1       sample accepted this cycle when in_valid is high
//   busy      out  1       command in progress
//   done      out  1       one-cycle pulse (stretched while clk_en is low)
//   result    out  DATA_W  saturated, shifted sum, held until next done
//   overflow  out  1       last result was saturated
module cordic_result_accumulator
  import cordic_pkg::*;
#(
  parameter int DATA_W    = FIXED_W,
  parameter int ACC_W     = 40,
  parameter int CNT_W     = 16,
  parameter int OUT_SHIFT = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clk_en,
  input  logic              start,
  input  logic [CNT_W-1:0]  count,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              overflow
);

  acc_state_t               state;
  acc_state_t               state_next;
  logic signed [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]         remaining;
  logic                     transfer;
  logic                     accept_start;
  logic signed [DATA_W-1:0] sat_value;
  logic                     sat_flag;

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else if (clk_en) begin
      state <= state_next;
    end
  end

  // Next-state logic; a zero-length command skips straight to FINISH
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = (count != '0) ? ACCUM : FINISH;
        end
      end
      ACCUM: begin
        if (transfer && (remaining == CNT_W'(1))) begin
          state_next = FINISH;
        end
      end
      FINISH: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake decode; in_ready is masked by clk_en so no sample is lost
  // while the datapath is frozen
  always_comb begin
    in_ready     = clk_en && (state == ACCUM);
    transfer     = in_valid && in_ready;
    accept_start = start && (state == IDLE);
  end

  fixed_saturate #(
    .IN_W  (ACC_W),
    .OUT_W (DATA_W),
    .SHIFT (OUT_SHIFT)
  ) u_sat (
    .in_value  (acc),
    .out_value (sat_value),
    .sat       (sat_flag)
  );

  // Accumulator, sample counter and output registers. done follows the
  // FINISH state one cycle later and is held while clk_en is low.
  always_ff @(posedge clock) begin
    if (reset) begin
      acc       <= '0;
      remaining <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      overflow  <= 1'b0;
    end else if (clk_en) begin
      done <= (state == FINISH);
      if (accept_start) begin
        acc       <= '0;
        remaining <= count;
        busy      <= 1'b1;
      end else if (transfer) begin
        acc       <= acc + {{(ACC_W-DATA_W){in_data[DATA_W-1]}}, in_data};
        remaining <= remaining - CNT_W'(1);
      end
      if (state == FINISH) begin
        result   <= sat_value;
        overflow <= sat_flag;
        busy     <= 1'b0;
      end
    end
  end

endmodule
